// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use hazard stall, bubble
//            insertion and branch-taken flush. Hazard logic is built only
//            when ID_EX_HAZARD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        wb_in,
  input  logic [2:0]        m_in,
  input  logic [3:0]        ex_in,
  input  logic              valid_in,
  input  logic              flush,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] pc4_in,
  input  logic [4:0]        rs_in,
  input  logic [4:0]        rt_in,
  input  logic [4:0]        rd_in,
  output logic [1:0]        wb_out,
  output logic [2:0]        m_out,
  output logic [3:0]        ex_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] pc4_out,
  output logic [4:0]        rs_out,
  output logic [4:0]        rt_out,
  output logic [4:0]        rd_out,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [1:0]        wb_q, wb_d;
  logic [2:0]        m_q, m_d;
  logic [3:0]        ex_q, ex_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc4_q, pc4_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic              stall_w;

`ifdef ID_EX_HAZARD_EN
  logic              hazard;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  // A load in EX whose target is read by the ID instruction; $zero is exempt.
  always_comb begin
    hazard  = valid_q & m_q[1] & (rt_q != 5'd0) &
              ((rt_q == rs_in) | (rt_q == rt_in));
    stall_w = hazard & ~flush;
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (stall_w && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bubble_cnt_q <= '0;
    else       bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_w    = 1'b0;
  assign bubble_cnt = '0;
`endif

  always_comb begin
    wb_d    = wb_in;
    m_d     = m_in;
    ex_d    = ex_in;
    valid_d = valid_in;
    // Flush and bubble both kill control; operand fields are captured regardless.
    if (flush || stall_w) begin
      wb_d    = 2'b00;
      m_d     = 3'b000;
      ex_d    = 4'b0000;
      valid_d = 1'b0;
    end
    rd1_d = rd1_in;
    rd2_d = rd2_in;
    imm_d = imm_in;
    pc4_d = pc4_in;
    rs_d  = rs_in;
    rt_d  = rt_in;
    rd_d  = rd_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q    <= '0;
      m_q     <= '0;
      ex_q    <= '0;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      wb_q    <= wb_d;
      m_q     <= m_d;
      ex_q    <= ex_d;
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

  assign wb_out    = wb_q;
  assign m_out     = m_q;
  assign ex_out    = ex_q;
  assign valid_out = valid_q;
  assign rd1_out   = rd1_q;
  assign rd2_out   = rd2_q;
  assign imm_out   = imm_q;
  assign pc4_out   = pc4_q;
  assign rs_out    = rs_q;
  assign rt_out    = rt_q;
  assign rd_out    = rd_q;
  assign stall     = stall_w;

endmodule
`default_nettype wire
